// File: rtl/niu32_io_pkg.sv
// niu32_io_pkg: shared constants and types for the Niu32 memory-mapped I/O
// controller: register byte offsets within the I/O page, handshake FSM state
// type, blank segment pattern and peripheral counts.
package niu32_io_pkg;

   localparam int unsigned NUM_KEYS   = 4;
   localparam int unsigned NUM_SW     = 10;
   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [11:0] OFF_HEX_VAL   = 12'h000;
   localparam logic [11:0] OFF_LEDR      = 12'h004;
   localparam logic [11:0] OFF_LEDG      = 12'h008;
   localparam logic [11:0] OFF_HEX_BLANK = 12'h00C;
   localparam logic [11:0] OFF_KEY_STATE = 12'h010;
   localparam logic [11:0] OFF_KEY_EVENT = 12'h014;
   localparam logic [11:0] OFF_KEY_MASK  = 12'h018;
   localparam logic [11:0] OFF_SW_STATE  = 12'h01C;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

endpackage

// File: rtl/niu32_io_ctrl_if.sv
// niu32_io_ctrl_if: load/store request/acknowledge bus between the Niu32 core
// (master) and the I/O controller (slave).
//   io_req/io_we/io_addr/io_wdata : request from core, held until io_ack
//   io_rdata/io_ack/io_err        : one-cycle response from controller
interface niu32_io_ctrl_if;
   logic        io_req;
   logic        io_we;
   logic [11:0] io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic        io_ack;
   logic        io_err;

   modport master (
      output io_req, io_we, io_addr, io_wdata,
      input  io_rdata, io_ack, io_err
   );

   modport slave (
      input  io_req, io_we, io_addr, io_wdata,
      output io_rdata, io_ack, io_err
   );
endinterface

// File: rtl/niu32_hex7seg.sv
// niu32_hex7seg: combinational hex nibble to seven-segment decoder.
//   nibble_i : value 0..F
//   seg_o    : segments {g,f,e,d,c,b,a}, active-low
module niu32_hex7seg (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = 7'b1111111;
      case (nibble_i)
         4'h0: seg_o = 7'b1000000;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         4'hF: seg_o = 7'b0001110;
         default: seg_o = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/niu32_io_ctrl.sv
// niu32_io_ctrl: memory-mapped I/O controller for the Niu32 core.
//   CLOCK_50 / RESET : clock, synchronous active-high reset
//   bus              : req/ack load/store port (slave side)
//   irq              : level interrupt, |(KEY_EVENT & KEY_MASK)
//   SW, KEY          : raw switches / active-low pushbuttons (asynchronous)
//   LEDR, LEDG       : LED registers
//   HEX0..HEX3       : active-low seven-segment digits, HEX0 least significant
module niu32_io_ctrl
   import niu32_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   niu32_io_ctrl_if.slave      bus,
   output logic                irq,
   input  logic [NUM_SW-1:0]   SW,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [9:0]          LEDR,
   output logic [7:0]          LEDG,
   output logic [6:0]          HEX0,
   output logic [6:0]          HEX1,
   output logic [6:0]          HEX2,
   output logic [6:0]          HEX3
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                accept, wr_en, addr_err;
   logic [31:0]         rd_val;

   logic [15:0]         hex_val_q;
   logic [9:0]          ledr_q;
   logic [7:0]          ledg_q;
   logic [3:0]          blank_q, mask_q;
   logic [NUM_KEYS-1:0] key_state_q, key_event_q, key_flip, key_rise, w1c;
   logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
   logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
   logic [6:0]          seg_raw [NUM_DIGITS];
   logic [6:0]          seg_out [NUM_DIGITS];
   logic                unused_wdata;

   assign unused_wdata = ^bus.io_wdata[31:16];

   // Only aligned words inside the 8-register window are mapped.
   assign addr_err = (bus.io_addr[1:0] != 2'b00) || (bus.io_addr > OFF_SW_STATE);

   always_comb begin
      rd_val = '0;
      case (bus.io_addr)
         OFF_HEX_VAL:   rd_val[15:0]         = hex_val_q;
         OFF_LEDR:      rd_val[9:0]          = ledr_q;
         OFF_LEDG:      rd_val[7:0]          = ledg_q;
         OFF_HEX_BLANK: rd_val[3:0]          = blank_q;
         OFF_KEY_STATE: rd_val[NUM_KEYS-1:0] = key_state_q;
         OFF_KEY_EVENT: rd_val[NUM_KEYS-1:0] = key_event_q;
         OFF_KEY_MASK:  rd_val[3:0]          = mask_q;
         OFF_SW_STATE:  rd_val[NUM_SW-1:0]   = sw_s2_q;
         default:       rd_val               = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      rdata_d = '0;
      err_d   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (bus.io_req) begin
            accept  = 1'b1;
            state_d = RESP;
            err_d   = addr_err;
            rdata_d = rd_val;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RESET gates the response so an ack pending when reset arrives never shows.
   assign bus.io_ack   = (state_q == RESP) && !RESET;
   assign bus.io_err   = err_q && !RESET;
   assign bus.io_rdata = rdata_q;

   assign wr_en    = accept && bus.io_we && !addr_err;
   assign w1c      = (wr_en && bus.io_addr == OFF_KEY_EVENT) ? bus.io_wdata[NUM_KEYS-1:0] : '0;
   assign key_rise = key_flip & ~key_state_q;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         hex_val_q   <= '0;
         ledr_q      <= '0;
         ledg_q      <= '0;
         blank_q     <= '1;
         mask_q      <= '0;
         key_state_q <= '0;
         key_event_q <= '0;
         key_s1_q    <= '0;
         key_s2_q    <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
      end else begin
         if (wr_en) begin
            case (bus.io_addr)
               OFF_HEX_VAL:   hex_val_q <= bus.io_wdata[15:0];
               OFF_LEDR:      ledr_q    <= bus.io_wdata[9:0];
               OFF_LEDG:      ledg_q    <= bus.io_wdata[7:0];
               OFF_HEX_BLANK: blank_q   <= bus.io_wdata[3:0];
               OFF_KEY_MASK:  mask_q    <= bus.io_wdata[3:0];
               default: ;
            endcase
         end
         key_state_q <= key_state_q ^ key_flip;
         // A press accepted on the same edge as a W1C clear keeps the event.
         key_event_q <= (key_event_q & ~w1c) | key_rise;
         key_s1_q    <= ~KEY;
         key_s2_q    <= key_s1_q;
         sw_s1_q     <= SW;
         sw_s2_q     <= sw_s1_q;
      end
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic             differ;
      assign differ      = key_s2_q[k] != key_state_q[k];
      assign key_flip[k] = differ && (cnt_q == CNT_MAX);
      always_ff @(posedge CLOCK_50) begin
         if (RESET || !differ || cnt_q == CNT_MAX) cnt_q <= '0;
         else                                      cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_hex
      niu32_hex7seg u_dec (
         .nibble_i (hex_val_q[4*d +: 4]),
         .seg_o    (seg_raw[d])
      );
      assign seg_out[d] = blank_q[d] ? SEG_BLANK : seg_raw[d];
   end

   assign HEX0 = seg_out[0];
   assign HEX1 = seg_out[1];
   assign HEX2 = seg_out[2];
   assign HEX3 = seg_out[3];
   assign LEDR = ledr_q;
   assign LEDG = ledg_q;
   assign irq  = |(key_event_q & mask_q);

endmodule

// File: tb/tb_niu32_io_ctrl.sv
// tb_niu32_io_ctrl: self-checking bench for niu32_io_ctrl with a 4-cycle
// debounce. Register accesses from a vector table, randomized accesses
// against a register-file model, and directed key/reset sequences.
module tb_niu32_io_ctrl;
   import niu32_io_pkg::*;

   logic       CLOCK_50 = 1'b0;
   logic       RESET    = 1'b1;
   logic       irq;
   logic [9:0] SW       = '0;
   logic [3:0] KEY      = 4'hF;
   logic [9:0] LEDR;
   logic [7:0] LEDG;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;

   always #5 CLOCK_50 = ~CLOCK_50;

   niu32_io_ctrl_if bus ();

   niu32_io_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .bus      (bus),
      .irq      (irq),
      .SW       (SW),
      .KEY      (KEY),
      .LEDR     (LEDR),
      .LEDG     (LEDG),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3)
   );

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference register file
   logic [15:0] m_hex;
   logic [9:0]  m_ledr, m_sw;
   logic [7:0]  m_ledg;
   logic [3:0]  m_blank, m_mask, m_event;
   logic [6:0]  seg_tab [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic bus_xfer(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
      int lat = 0;
      @(negedge CLOCK_50);
      bus.io_req = 1'b1; bus.io_we = we; bus.io_addr = addr; bus.io_wdata = wd;
      do begin
         @(posedge CLOCK_50); #1;
         lat++;
      end while (!bus.io_ack && lat < 5);
      rd  = bus.io_rdata;
      err = bus.io_err;
      bus.io_req = 1'b0;
      chk("ack_latency", 32'(lat), 32'd1);
      @(posedge CLOCK_50); #1;
      chk("ack_one_cycle", 32'(bus.io_ack), 32'd0);
   endtask

   task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] rd; logic err;
      bus_xfer(1'b0, addr, '0, rd, err);
      chk(name, rd, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
      logic [31:0] rd; logic err;
      bus_xfer(1'b1, addr, wd, rd, err);
      chk("wr_err", 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      RESET = 1'b1; KEY = 4'hF; SW = '0; bus.io_req = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET = 1'b0;
      m_hex = '0; m_ledr = '0; m_ledg = '0; m_blank = 4'hF;
      m_mask = '0; m_event = '0; m_sw = '0;
   endtask

   // Register behaviour as seen from the bus, with no keys pressed.
   task automatic model_access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err);
      rd  = '0;
      err = (addr[1:0] != 2'b00) || (addr > 12'h01C);
      if (!err) begin
         case (addr)
            12'h000: begin rd = {16'h0, m_hex};   if (we) m_hex   = wd[15:0]; end
            12'h004: begin rd = {22'h0, m_ledr};  if (we) m_ledr  = wd[9:0];  end
            12'h008: begin rd = {24'h0, m_ledg};  if (we) m_ledg  = wd[7:0];  end
            12'h00C: begin rd = {28'h0, m_blank}; if (we) m_blank = wd[3:0];  end
            12'h010: rd = '0;
            12'h014: begin rd = {28'h0, m_event}; if (we) m_event = m_event & ~wd[3:0]; end
            12'h018: begin rd = {28'h0, m_mask};  if (we) m_mask  = wd[3:0];  end
            default: rd = {22'h0, m_sw};
         endcase
      end
   endtask

   function automatic logic [6:0] exp_digit(input int d);
      if (m_blank[d]) return 7'b1111111;
      return seg_tab[m_hex[4*d +: 4]];
   endfunction

   task automatic chk_outputs();
      chk("LEDR", 32'(LEDR), 32'(m_ledr));
      chk("LEDG", 32'(LEDG), 32'(m_ledg));
      chk("HEX0", 32'(HEX0), 32'(exp_digit(0)));
      chk("HEX1", 32'(HEX1), 32'(exp_digit(1)));
      chk("HEX2", 32'(HEX2), 32'(exp_digit(2)));
      chk("HEX3", 32'(HEX3), 32'(exp_digit(3)));
      chk("irq",  32'(irq),  32'(|(m_event & m_mask)));
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] rd, mrd;
      logic        err, merr, we;
      logic [11:0] addr;
      logic [31:0] wd;
      int          rise_at;

      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;

      // Reset state
      do_reset();
      @(posedge CLOCK_50); #1;
      chk("rst_ack",   32'(bus.io_ack), 32'd0);
      chk("rst_rdata", bus.io_rdata, 32'd0);
      chk_outputs();
      chk("rst_HEX_blank", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0FFFFFFF);

      // Table-driven register accesses
      vecs.push_back('{1'b0, 12'h00C, 32'h0,        32'hF,   1'b0});
      vecs.push_back('{1'b1, 12'h00C, 32'h0,        32'h0,   1'b0});
      vecs.push_back('{1'b1, 12'h000, 32'h00001234, 32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h000, 32'h0,        32'h1234, 1'b0});
      vecs.push_back('{1'b1, 12'h004, 32'hFFFFFFFF, 32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h3FF, 1'b0});
      vecs.push_back('{1'b1, 12'h008, 32'h000001A5, 32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h008, 32'h0,        32'hA5,  1'b0});
      vecs.push_back('{1'b0, 12'h0FC, 32'h0,        32'h0,   1'b1});
      vecs.push_back('{1'b1, 12'h006, 32'h0,        32'h0,   1'b1});
      vecs.push_back('{1'b0, 12'h004, 32'h0,        32'h3FF, 1'b0});
      vecs.push_back('{1'b1, 12'h010, 32'hF,        32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h010, 32'h0,        32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h020, 32'h0,        32'h0,   1'b1});
      vecs.push_back('{1'b1, 12'h018, 32'hFF,       32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h018, 32'h0,        32'hF,   1'b0});
      vecs.push_back('{1'b1, 12'h018, 32'h0,        32'h0,   1'b0});
      vecs.push_back('{1'b0, 12'h01C, 32'h0,        32'h0,   1'b0});
      foreach (vecs[i]) begin
         bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, err);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         if (!vecs[i].we || vecs[i].exp_err)
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
      chk("LEDR_after_tab", 32'(LEDR), 32'h3FF);
      chk("LEDG_after_tab", 32'(LEDG), 32'hA5);
      chk("HEX3_1", 32'(HEX3), 32'(7'b1111001));
      chk("HEX2_2", 32'(HEX2), 32'(7'b0100100));
      chk("HEX1_3", 32'(HEX1), 32'(7'b0110000));
      chk("HEX0_4", 32'(HEX0), 32'(7'b0011001));
      wr(12'h00C, 32'h2);
      chk("HEX1_blank", 32'(HEX1), 32'(7'b1111111));
      chk("HEX_others", 32'({HEX3, HEX2, HEX0}), 32'({7'b1111001, 7'b0100100, 7'b0011001}));

      // Randomized accesses against the register model
      do_reset();
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLOCK_50);
            SW = 10'($urandom);
            m_sw = SW;
            repeat (3) @(posedge CLOCK_50);
         end
         we   = 1'($urandom);
         wd   = $urandom;
         addr = ($urandom_range(0, 9) < 7) ? 12'(4 * $urandom_range(0, 7)) : 12'($urandom);
         model_access(we, addr, wd, mrd, merr);
         bus_xfer(we, addr, wd, rd, err);
         chk($sformatf("rnd%0d_err@%h", it, addr), 32'(err), 32'(merr));
         if (!we || merr) chk($sformatf("rnd%0d_rdata@%h", it, addr), rd, mrd);
         chk_outputs();
      end

      // Debounce: a 3-cycle glitch is rejected
      do_reset();
      @(negedge CLOCK_50); KEY[0] = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      repeat (10) @(posedge CLOCK_50);
      rd_chk("glitch_key_state", 12'h010, 32'h0);
      rd_chk("glitch_key_event", 12'h014, 32'h0);

      // Debounce: accepted press, timed through irq with the mask set
      wr(12'h018, 32'h1);
      @(negedge CLOCK_50); KEY[0] = 1'b0;
      rise_at = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge CLOCK_50); #1;
         if (irq && rise_at == 0) rise_at = i;
      end
      chk("press_latency", 32'(rise_at), 32'd6);
      rd_chk("press_key_state", 12'h010, 32'h1);
      rd_chk("press_key_event", 12'h014, 32'h1);
      wr(12'h014, 32'h1);
      rd_chk("w1c_key_event", 12'h014, 32'h0);
      chk("w1c_irq", 32'(irq), 32'd0);
      wr(12'h018, 32'h0);
      @(negedge CLOCK_50); KEY[0] = 1'b1;
      repeat (10) @(posedge CLOCK_50);
      rd_chk("release_key_state", 12'h010, 32'h0);
      rd_chk("release_no_event", 12'h014, 32'h0);

      // Event latched while masked; irq follows the mask write
      @(negedge CLOCK_50); KEY[0] = 1'b0;
      repeat (10) @(posedge CLOCK_50);
      #1 chk("masked_irq", 32'(irq), 32'd0);
      rd_chk("masked_event", 12'h014, 32'h1);
      wr(12'h018, 32'h1);
      chk("unmasked_irq", 32'(irq), 32'd1);
      wr(12'h014, 32'h1);
      @(negedge CLOCK_50); KEY[0] = 1'b1;
      repeat (10) @(posedge CLOCK_50);

      // W1C sampled on the very edge the new press is accepted
      @(negedge CLOCK_50); KEY[0] = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      wr(12'h014, 32'h1);
      rd_chk("race_event_kept", 12'h014, 32'h1);
      chk("race_irq", 32'(irq), 32'd1);

      // Reset while in RESP drops the ack and undoes the write
      do_reset();
      @(negedge CLOCK_50);
      bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 12'h004; bus.io_wdata = 32'h3FF;
      @(posedge CLOCK_50); #1;
      chk("resp_LEDR_committed", 32'(LEDR), 32'h3FF);
      RESET = 1'b1; bus.io_req = 1'b0;
      #1 chk("resp_rst_ack", 32'(bus.io_ack), 32'd0);
      @(posedge CLOCK_50); #1;
      chk("resp_rst_ack2", 32'(bus.io_ack), 32'd0);
      chk("resp_rst_LEDR", 32'(LEDR), 32'd0);

      // Request held across reset release is served right after
      bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 12'h00C;
      @(posedge CLOCK_50); #1;
      chk("held_req_in_reset", 32'(bus.io_ack), 32'd0);
      @(negedge CLOCK_50); RESET = 1'b0;
      @(posedge CLOCK_50); #1;
      chk("held_req_ack", 32'(bus.io_ack), 32'd1);
      chk("held_req_rdata", bus.io_rdata, 32'hF);
      bus.io_req = 1'b0;
      @(posedge CLOCK_50); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/niu32_io_ctrl.md
# niu32_io_ctrl

Memory-mapped I/O controller between the Niu32 multicycle core's load/store path and the board peripherals (SW, KEY, LEDR, LEDG, HEX0–HEX3). It decodes word accesses in the 4 KiB I/O page and answers them through a single req/ack handshake. It holds the LED and seven-segment display registers, and synchronizes and debounces the switches and pushbuttons. It also latches button-press events and raises an interrupt request from them. It replaces the constant debug drive of the board outputs at the top level.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a KEY change (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CLOCK_50  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- io_req  in  1  access request from core; held until io_ack.
- io_we  in  1  1 = write, 0 = read; valid with io_req.
- io_addr  in  12  byte offset within I/O page.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data; valid while io_ack = 1.
- io_ack  out  1  one-cycle completion pulse.
- io_err  out  1  with io_ack: access was unmapped or misaligned.
- irq  out  1  level interrupt, |(key_event & key_mask).
- SW  in  10  raw slide switches, asynchronous.
- KEY  in  4  raw pushbuttons, asynchronous, active-low.
- LEDR  out  10  red LEDs.
- LEDG  out  8  green LEDs.
- HEX0..HEX3  out  7 each  segments {g,f,e,d,c,b,a}, active-low; HEX0 = least significant digit.

## Operation
- Register map (word offsets; reads return unused bits as 0):
  - 0x000 HEX_VAL: bits [15:0], R/W, four hex nibbles.
  - 0x004 LEDR: bits [9:0], R/W.
  - 0x008 LEDG: bits [7:0], R/W.
  - 0x00C HEX_BLANK: bits [3:0], R/W. A set bit blanks that digit, driving 7'b1111111.
  - 0x010 KEY_STATE: bits [3:0], RO, debounced state, 1 = pressed.
  - 0x014 KEY_EVENT: bits [3:0], sticky press events, write-1-to-clear.
  - 0x018 KEY_MASK: bits [3:0], R/W.
  - 0x01C SW_STATE: bits [9:0], RO, synchronized switches.
- Any other offset, or io_addr[1:0] != 0:
  - The access is acknowledged with io_err = 1.
  - No state changes; io_rdata = 0.
  - Writes to RO registers are silently ignored (io_err = 0).
- Handshake FSM, two states:
  - IDLE: if io_req is sampled at 1, perform the write (or capture the read data) at that edge, register io_rdata/io_err, and go to RESP.
  - RESP: io_ack = 1 for exactly one cycle, then return to IDLE.
  - The core must deassert io_req in the cycle after it sees io_ack. An io_req seen in IDLE is always a new transaction.
- Input sync: SW and inverted KEY each pass through two flip-flops.
- Debounce, per key: compare the synced value against KEY_STATE.
  - While they differ, the counter increments.
  - If they match, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, KEY_STATE flips and the counter clears.
- A 0→1 transition of a KEY_STATE bit sets the matching KEY_EVENT bit. A set and a W1C clear on the same bit in the same cycle: set wins.
- HEX outputs are the nibble-to-segment decode of HEX_VAL, overridden by HEX_BLANK.

## Timing
- Reset values:
  - FSM = IDLE; io_ack, io_err, io_rdata, irq = 0.
  - LEDR, LEDG, HEX_VAL = 0; HEX_BLANK = 4'hF, so all HEX outputs = 7'b1111111.
  - KEY_STATE, KEY_EVENT, KEY_MASK, debounce counters, synchronizers = 0.
- Access latency: io_ack is asserted in the cycle after io_req is sampled. Sustained throughput is one access per 2 cycles.
- A written value is visible on LEDR/LEDG/HEX outputs in the same cycle io_ack rises.
- KEY latency, press to KEY_STATE: 2 synchronizer cycles + DEBOUNCE_CYCLES. KEY_EVENT and irq update on the same edge as KEY_STATE.
- SW_STATE lags SW by 2 cycles. There is no debounce on SW.
- RESET asserted in RESP: the pending ack is dropped; register effects already committed are then reset too.
- io_req held across the deassertion of RESET is sampled on the first cycle after RESET falls.

## Structure
- Package niu32_io_pkg holds:
  - register offset constants;
  - the state enum {IDLE, RESP};
  - SEG_BLANK = 7'b1111111;
  - the key/switch counts (4, 10).
- Sub-module niu32_hex7seg: combinational 4-bit to 7-segment active-low decoder, instanced four times.
- Debounce is a generate loop inside niu32_io_ctrl; there is no separate module.

## Test plan
- Reset then idle: all HEX = 7'b1111111, LEDR = 0, LEDG = 0, irq = 0. A read of 0x00C returns 0x0000000F with ack one cycle after req.
- Display write:
  - Stimulus: write 0x00C ← 0, then 0x000 ← 0x00001234.
  - Required: HEX3 = 7'b1111001, HEX2 = 7'b0100100, HEX1 = 7'b0110000, HEX0 = 7'b0011001.
  - Then write 0x00C ← 0x2: HEX1 = 7'b1111111, other digits unchanged.
- Debounce, run with DEBOUNCE_CYCLES = 4:
  - KEY[0] low for 3 cycles: KEY_STATE stays 0.
  - KEY[0] low for 10 cycles: KEY_STATE = 0x1 at sync+4 cycles, KEY_EVENT = 0x1; irq = 1 only after KEY_MASK ← 0x1.
- W1C race: write 0x014 ← 0x1 on the same edge as a new KEY[0] press is accepted. KEY_EVENT[0] remains 1.
- Error path: a read of 0x0FC and a write to 0x006 each ack with io_err = 1, io_rdata = 0, and no register change.
- Reset in RESP: write LEDR ← 0x3FF, assert RESET during RESP. No io_ack appears and LEDR = 0 afterwards.
